// File: rtl/hnoc_pkg.sv
// Shared definitions for the HNoC PE endpoint: packet field positions,
// default widths and status-counter widths.
package hnoc_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 3;

    localparam int unsigned TX_CNT_W  = 16;
    localparam int unsigned RX_CNT_W  = 16;
    localparam int unsigned MIS_CNT_W = 8;

    // Packets are {addr, payload}; payload always starts at bit 0.
    localparam int unsigned PKT_PAYLOAD_LSB = 0;

    function automatic int unsigned pkt_addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned pkt_width(input int unsigned data_w,
                                              input int unsigned addr_w);
        return data_w + addr_w;
    endfunction

    function automatic logic [MIS_CNT_W-1:0] sat_inc_mis(input logic [MIS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hnoc_ep_fifo.sv
// First-word-fall-through FIFO, power-of-two depth; head visible the cycle after push,
// reads as zero when empty. Push is ignored when full, pop ignored when empty.
module hnoc_ep_fifo
    import hnoc_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Gating the head on empty keeps stale entries off the output after reset.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/hnoc_pe_endpoint.sv
// PE-side NoC endpoint: core words buffered out to the NoC, packets for MyAddr buffered in;
// one-cycle FIFO latency each way, ready = FIFO not-full, all handshakes valid/ready.
module hnoc_pe_endpoint
    import hnoc_pkg::*;
#(
    parameter int unsigned DataWidth = DEF_DATA_W,
    parameter int unsigned AddrWidth = DEF_ADDR_W,
    parameter int unsigned MyAddr    = 0,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,

    input  logic [AddrWidth-1:0]           i_tx_dest,
    input  logic [DataWidth-1:0]           i_tx_data,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,

    output logic [DataWidth+AddrWidth-1:0] o_noc_data,
    output logic                           o_noc_data_valid,
    input  logic                           i_noc_data_ready,

    input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
    input  logic                           i_noc_data_valid,
    output logic                           o_noc_data_ready,

    output logic [DataWidth-1:0]           o_rx_data,
    output logic                           o_rx_valid,
    input  logic                           i_rx_ready,

    input  logic                           i_clr_counts,
    output logic [TX_CNT_W-1:0]            o_tx_count,
    output logic [RX_CNT_W-1:0]            o_rx_count,
    output logic [MIS_CNT_W-1:0]           o_misroute_count
);

    localparam int unsigned PktW    = pkt_width(DataWidth, AddrWidth);
    localparam int unsigned AddrLsb = pkt_addr_lsb(DataWidth);

    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic                 noc_accept, for_me, misroute;
    logic [AddrWidth-1:0] rx_addr;
    logic [PktW-1:0]      tx_pkt;

    logic [TX_CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RX_CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [MIS_CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    // Readies are forced low for the whole reset window, not just until the first edge.
    assign o_tx_ready       = i_reset & ~tx_full;
    assign tx_push          = i_tx_valid & o_tx_ready;
    assign tx_pkt           = {i_tx_dest, i_tx_data};
    assign o_noc_data_valid = ~tx_empty;
    assign tx_pop           = o_noc_data_valid & i_noc_data_ready;

    assign o_noc_data_ready = i_reset & ~rx_full;
    assign noc_accept       = i_noc_data_valid & o_noc_data_ready;
    assign rx_addr          = i_noc_data[AddrLsb +: AddrWidth];
    assign for_me           = (rx_addr == AddrWidth'(MyAddr));
    assign rx_push          = noc_accept & for_me;
    assign misroute         = noc_accept & ~for_me;
    assign o_rx_valid       = ~rx_empty;
    assign rx_pop           = o_rx_valid & i_rx_ready;

    hnoc_ep_fifo #(
        .Width (PktW),
        .Depth (FifoDepth)
    ) u_tx_fifo (
        .clk_i   (i_sclk),
        .rst_ni  (i_reset),
        .push_i  (tx_push),
        .data_i  (tx_pkt),
        .pop_i   (tx_pop),
        .data_o  (o_noc_data),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    hnoc_ep_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_rx_fifo (
        .clk_i   (i_sclk),
        .rst_ni  (i_reset),
        .push_i  (rx_push),
        .data_i  (i_noc_data[PKT_PAYLOAD_LSB +: DataWidth]),
        .pop_i   (rx_pop),
        .data_o  (o_rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // Clear wins over any increment landing on the same edge.
    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (i_clr_counts) begin
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (tx_pop) begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
            if (rx_pop) begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
            if (misroute) begin
                mis_cnt_d = sat_inc_mis(mis_cnt_q);
            end
        end
    end

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign o_tx_count       = tx_cnt_q;
    assign o_rx_count       = rx_cnt_q;
    assign o_misroute_count = mis_cnt_q;

endmodule

// File: doc/hnoc_pe_endpoint.md
HNOC_PE_ENDPOINT -- requirements
Module: hnoc_pe_endpoint

Interface
REQ-001 Parameter DataWidth, default 32, payload bits per packet.
REQ-002 Parameter AddrWidth, default 3, destination-address bits per packet.
REQ-003 Parameter MyAddr, default 0, this endpoint's PE index.
REQ-004 Parameter FifoDepth, default 4, entries per FIFO, power of two and at least 2.
REQ-005 Port i_sclk, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port i_reset, input, 1, asynchronous reset, active-low.
REQ-007 Port i_tx_dest, input, AddrWidth, destination PE for the core's outgoing word.
REQ-008 Port i_tx_data, input, DataWidth, core outgoing payload.
REQ-009 Port i_tx_valid / o_tx_ready, in/out, 1 each, core-to-endpoint handshake.
REQ-010 Port o_noc_data, output, DataWidth+AddrWidth, packet to the NoC PE input.
REQ-011 Port o_noc_data_valid / i_noc_data_ready, out/in, 1 each, endpoint-to-NoC handshake.
REQ-012 Port i_noc_data, input, DataWidth+AddrWidth, packet from the NoC PE output.
REQ-013 Port i_noc_data_valid / o_noc_data_ready, in/out, 1 each, NoC-to-endpoint handshake.
REQ-014 Port o_rx_data, output, DataWidth, received payload to the core.
REQ-015 Port o_rx_valid / i_rx_ready, out/in, 1 each, endpoint-to-core handshake.
REQ-016 Port i_clr_counts, input, 1, synchronous clear of all status counters.
REQ-017 Ports o_tx_count (16), o_rx_count (16) and o_misroute_count (8), outputs, status counters.

Function
REQ-018 Packet format SHALL be {addr, payload}: address in bits [DataWidth+AddrWidth-1:DataWidth], payload in bits [DataWidth-1:0].
REQ-019 A transfer SHALL occur on any interface only in a cycle where valid and ready are both high at the clock edge.
REQ-020 TX path SHALL buffer {i_tx_dest, i_tx_data} in a FifoDepth-entry FIFO; o_tx_ready SHALL equal not-full, independent of i_tx_valid.
REQ-021 o_noc_data SHALL present the TX FIFO head (first-word fall-through); o_noc_data_valid SHALL equal TX not-empty.
REQ-022 A word accepted from the core at edge N SHALL appear on o_noc_data with valid high after edge N; there is no combinational bypass.
REQ-023 While o_noc_data_valid is high and i_noc_data_ready is low, o_noc_data SHALL hold stable.
REQ-024 Simultaneous push and pop on a FIFO SHALL both take effect, leaving occupancy unchanged; pointers SHALL wrap modulo FifoDepth.
REQ-025 o_noc_data_ready SHALL equal RX FIFO not-full and SHALL NOT depend on i_noc_data or i_noc_data_valid.
REQ-026 An accepted packet whose address equals MyAddr SHALL be pushed into the RX FIFO payload-only.
REQ-027 An accepted packet whose address differs from MyAddr SHALL be discarded and SHALL increment o_misroute_count.
REQ-028 o_rx_data and o_rx_valid SHALL present the RX FIFO head, first-word fall-through, and SHALL hold stable while stalled.
REQ-029 o_tx_count SHALL increment on each NoC-side TX transfer and wrap at 2^16.
REQ-030 o_rx_count SHALL increment on each core-side RX transfer and wrap at 2^16.
REQ-031 o_misroute_count SHALL saturate at 255.
REQ-032 i_clr_counts SHALL zero all counters on the next edge, overriding any same-cycle increment.
REQ-033 A packet addressed to MyAddr on the TX side SHALL be sent to the NoC unchanged.

Reset
REQ-034 While i_reset is low: both FIFOs empty, all counters 0, o_tx_ready=0, o_noc_data_ready=0, o_noc_data_valid=0, o_rx_valid=0, o_noc_data=0, o_rx_data=0.
REQ-035 In the first cycle after i_reset deasserts, o_tx_ready=1 and o_noc_data_ready=1.
REQ-036 Reset asserted mid-transfer SHALL discard all buffered packets, with no partial transfer afterwards.

Structure
REQ-037 The shared package hnoc_pkg SHALL hold packet field-position constants and default DataWidth/AddrWidth.
REQ-038 One sub-module, hnoc_ep_fifo (parameterised width/depth, FWFT, full/empty flags), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-039 Push dest=5, data=0xDEADBEEF with i_noc_data_ready=1 -> o_noc_data=0x5DEADBEEF valid one cycle after accept; o_tx_count=1.
REQ-040 Hold i_noc_data_ready=0, push 5 words -> o_tx_ready low after the 4th push; release ready -> all 4 drain in order, then the 5th is accepted.
REQ-041 MyAddr=2, inject 0x2_00000011 then 0x3_00000022 -> o_rx_data=0x11 only; o_misroute_count=1.
REQ-042 i_rx_ready=0, inject 5 packets for MyAddr -> o_noc_data_ready=0 after 4; o_rx_data holds the first payload stable.
REQ-043 Inject 300 misrouted packets, then pulse i_clr_counts in the same cycle as an RX transfer -> count saturates at 255, then all counters read 0.
REQ-044 Assert i_reset with both FIFOs half full -> all valids 0 immediately (asynchronous), counters 0; no stale data after release.
